// File: rtl/timer_display_conv.sv
// rtl/timer_display_conv.sv - binary seconds to BCD days/hours/minutes/seconds, sequential divide + double-dabble
// Optional macro TDISP_ZERO_BLANK_EN: leading zero day digits are output as 4'hF.
module timer_display_conv #(
    parameter int IN_W       = 28,
    parameter int AUTO_START = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] t_in,
    input  logic            start,
    output logic            busy,
    output logic            valid,
    output logic [15:0]     day_bcd,
    output logic [7:0]      hr_bcd,
    output logic [7:0]      min_bcd,
    output logic [7:0]      sec_bcd
);

    typedef enum logic [2:0] {IDLE, DAY, HOUR, MIN, BCD, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [27:0] t_ext, last_acc, dvd;
    logic [16:0] rem;
    logic [11:0] day_q;
    logic [4:0]  hr_q;
    logic [5:0]  min_q, sec_q;
    logic [27:0] dd_day;
    logic [19:0] dd_hr, dd_min, dd_sec;

    logic        auto_req, accept, ge;
    logic [17:0] divisor, rs;
    logic [16:0] rem_next;
    logic [27:0] dvd_next;
    logic [27:0] dd_day_step;
    logic [19:0] dd_hr_step, dd_min_step, dd_sec_step;
    logic [15:0] day_disp;

    // One double-dabble step on a {16-bit BCD, 12-bit binary} field.
    function automatic logic [27:0] dd_step(input logic [27:0] v);
        logic [27:0] a;
        a = v;
        for (int i = 0; i < 4; i++) begin
            if (a[12+4*i +: 4] >= 4'd5)
                a[12+4*i +: 4] = a[12+4*i +: 4] + 4'd3;
        end
        return {a[26:0], 1'b0};
    endfunction

`ifdef TDISP_ZERO_BLANK_EN
    function automatic logic [15:0] blank_day(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[15:12] == 4'd0) r[15:12] = 4'hF;
        if (d[15:8] == 8'd0)  r[11:8]  = 4'hF;
        if (d[15:4] == 12'd0) r[7:4]   = 4'hF;
        return r;
    endfunction
`endif

    assign t_ext    = 28'(t_in);
    assign auto_req = (AUTO_START != 0) && (t_ext != last_acc);
    assign accept   = ((state == IDLE) || (state == DONE)) && (start || auto_req);

    // Shared restoring divider: dividend shifts out MSB-first, quotient bits shift in at the LSB.
    always_comb begin
        divisor = 18'd60;
        case (state)
            DAY:     divisor = 18'd86400;
            HOUR:    divisor = 18'd3600;
            default: divisor = 18'd60;
        endcase
    end

    assign rs       = {rem, dvd[27]};
    assign ge       = (rs >= divisor);
    assign rem_next = ge ? 17'(rs - divisor) : rs[16:0];
    assign dvd_next = {dvd[26:0], ge};

    assign dd_day_step = dd_step(dd_day);
    assign dd_hr_step  = 20'(dd_step({8'd0, dd_hr}));
    assign dd_min_step = 20'(dd_step({8'd0, dd_min}));
    assign dd_sec_step = 20'(dd_step({8'd0, dd_sec}));

`ifdef TDISP_ZERO_BLANK_EN
    assign day_disp = blank_day(dd_day_step[27:12]);
`else
    assign day_disp = dd_day_step[27:12];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // DONE doubles as an idle slot so a held start gives one result every 71 cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = DAY;
            DONE:    state_next = accept ? DAY : IDLE;
            DAY:     if (cnt == 5'd0) state_next = HOUR;
            HOUR:    if (cnt == 5'd0) state_next = MIN;
            MIN:     if (cnt == 5'd0) state_next = BCD;
            BCD:     if (cnt == 5'd0) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            valid    <= 1'b0;
            day_bcd  <= 16'd0;
            hr_bcd   <= 8'd0;
            min_bcd  <= 8'd0;
            sec_bcd  <= 8'd0;
            cnt      <= 5'd0;
            last_acc <= 28'd0;
            dvd      <= 28'd0;
            rem      <= 17'd0;
            day_q    <= 12'd0;
            hr_q     <= 5'd0;
            min_q    <= 6'd0;
            sec_q    <= 6'd0;
            dd_day   <= 28'd0;
            dd_hr    <= 20'd0;
            dd_min   <= 20'd0;
            dd_sec   <= 20'd0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        dvd      <= t_ext;
                        last_acc <= t_ext;
                        rem      <= 17'd0;
                        cnt      <= 5'd27;
                        busy     <= 1'b1;
                    end
                end
                DAY: begin
                    dvd <= dvd_next;
                    rem <= rem_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        day_q <= dvd_next[11:0];
                        dvd   <= {rem_next, 11'd0};
                        rem   <= 17'd0;
                        cnt   <= 5'd16;
                    end
                end
                HOUR: begin
                    dvd <= dvd_next;
                    rem <= rem_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        hr_q <= dvd_next[4:0];
                        dvd  <= {rem_next[11:0], 16'd0};
                        rem  <= 17'd0;
                        cnt  <= 5'd11;
                    end
                end
                MIN: begin
                    dvd <= dvd_next;
                    rem <= rem_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        min_q <= dvd_next[5:0];
                        sec_q <= rem_next[5:0];
                        cnt   <= 5'd12;
                    end
                end
                BCD: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd12) begin
                        // first BCD cycle loads the four binary fields
                        dd_day <= {16'd0, day_q};
                        dd_hr  <= {8'd0, 7'd0, hr_q};
                        dd_min <= {8'd0, 6'd0, min_q};
                        dd_sec <= {8'd0, 6'd0, sec_q};
                    end else begin
                        dd_day <= dd_day_step;
                        dd_hr  <= dd_hr_step;
                        dd_min <= dd_min_step;
                        dd_sec <= dd_sec_step;
                    end
                    if (cnt == 5'd0) begin
                        day_bcd <= day_disp;
                        hr_bcd  <= dd_hr_step[19:12];
                        min_bcd <= dd_min_step[19:12];
                        sec_bcd <= dd_sec_step[19:12];
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_display_conv.sv
// tb/tb_timer_display_conv.sv - directed vector bench for timer_display_conv
module tb_timer_display_conv;

    logic        clk, rst_n;
    logic [27:0] t_in, t_a;
    logic        start, start_a;
    logic        busy, valid, busy_a, valid_a;
    logic [15:0] day_bcd, day_a;
    logic [7:0]  hr_bcd, min_bcd, sec_bcd, hr_a, min_a, sec_a;

    int n_checks = 0;
    int n_fail   = 0;

    timer_display_conv #(.IN_W(28), .AUTO_START(0)) dut (
        .clk(clk), .reset(rst_n), .t_in(t_in), .start(start),
        .busy(busy), .valid(valid), .day_bcd(day_bcd),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd)
    );

    timer_display_conv #(.IN_W(28), .AUTO_START(1)) dut_a (
        .clk(clk), .reset(rst_n), .t_in(t_a), .start(start_a),
        .busy(busy_a), .valid(valid_a), .day_bcd(day_a),
        .hr_bcd(hr_a), .min_bcd(min_a), .sec_bcd(sec_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] t;
        logic [15:0] day;
        logic [7:0]  hr;
        logic [7:0]  mn;
        logic [7:0]  sc;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [15:0] exp_day(input logic [15:0] d);
        logic [15:0] r;
        r = d;
`ifdef TDISP_ZERO_BLANK_EN
        if (d[15:12] == 4'd0) r[15:12] = 4'hF;
        if (d[15:8] == 8'd0)  r[11:8]  = 4'hF;
        if (d[15:4] == 12'd0) r[7:4]   = 4'hF;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " day"}, {16'd0, day_bcd}, {16'd0, exp_day(v.day)});
        check({tag, " hr"},  {24'd0, hr_bcd},  {24'd0, v.hr});
        check({tag, " min"}, {24'd0, min_bcd}, {24'd0, v.mn});
        check({tag, " sec"}, {24'd0, sec_bcd}, {24'd0, v.sc});
    endtask

    // Pulse start with t, then sample at each falling edge until valid; i counts edges after acceptance.
    task automatic run_conv(input string tag, input vec_t v);
        int lat, busy_cnt;
        @(negedge clk);
        t_in = v.t;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (valid) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(lat), 32'd70);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'd70);
        check({tag, " busy at valid"}, {31'd0, busy}, 32'd0);
        check_outputs(tag, v);
        @(negedge clk);
        check({tag, " valid pulse width"}, {31'd0, valid}, 32'd0);
    endtask

    vec_t v;
    int   lat, gap, nval;
    logic [7:0] last_sec;

    initial begin
        vecs[0] = '{28'd0,         16'h0000, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{28'd86399,     16'h0000, 8'h23, 8'h59, 8'h59};
        vecs[2] = '{28'd86400,     16'h0001, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{28'd90061,     16'h0001, 8'h01, 8'h01, 8'h01};
        vecs[4] = '{28'd268435455, 16'h3106, 8'h21, 8'h24, 8'h15};
        vecs[5] = '{28'd3661,      16'h0000, 8'h01, 8'h01, 8'h01};
        vecs[6] = '{28'd1000000,   16'h0011, 8'h13, 8'h46, 8'h40};
        vecs[7] = '{28'd59,        16'h0000, 8'h00, 8'h00, 8'h59};

        rst_n = 1'b0; start = 1'b0; t_in = 28'd0; start_a = 1'b0; t_a = 28'd0;
        repeat (3) @(negedge clk);
        check("reset busy",  {31'd0, busy},  32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset day",   {16'd0, day_bcd}, 32'd0);
        check("reset hr",    {24'd0, hr_bcd},  32'd0);
        check("reset min",   {24'd0, min_bcd}, 32'd0);
        check("reset sec",   {24'd0, sec_bcd}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 8; k++)
            run_conv($sformatf("vec%0d", k), vecs[k]);

        // Second start while busy must be ignored.
        @(negedge clk);
        t_in = 28'd100; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (i == 20) begin t_in = 28'd5; start = 1'b1; end
            if (i == 21) start = 1'b0;
            if (valid) begin lat = i; break; end
            @(negedge clk);
        end
        check("ignore latency", 32'(lat), 32'd70);
        check("ignore min", {24'd0, min_bcd}, 32'h01);
        check("ignore sec", {24'd0, sec_bcd}, 32'h40);
        nval = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (valid) nval++;
        end
        check("ignore extra valid", 32'(nval), 32'd0);

        // Held start: results every 71 cycles.
        t_in = 28'd3661; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = -1; gap = -1;
        for (int i = 0; i < 300; i++) begin
            if (valid) begin
                if (lat < 0) lat = i;
                else begin gap = i - lat; break; end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b first latency", 32'(lat), 32'd70);
        check("b2b period", 32'(gap), 32'd71);
        v = vecs[5];
        check_outputs("b2b", v);
        repeat (100) @(negedge clk);
        check("b2b stops", {31'd0, busy}, 32'd0);

        // Reset mid-conversion.
        t_in = 28'd90061; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (35) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy",  {31'd0, busy},  32'd0);
        check("midreset valid", {31'd0, valid}, 32'd0);
        check("midreset day",   {16'd0, day_bcd}, 32'd0);
        check("midreset hr",    {24'd0, hr_bcd},  32'd0);
        check("midreset min",   {24'd0, min_bcd}, 32'd0);
        check("midreset sec",   {24'd0, sec_bcd}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid || busy) nval++;
        end
        check("midreset no result", 32'(nval), 32'd0);
        run_conv("after reset", vecs[3]);

        // Auto-start instance: one result per t_in change, none when held.
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            t_a = 28'(10 - s);
            nval = 0;
            last_sec = 8'hAA;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (valid_a) begin nval++; last_sec = sec_a; end
            end
            check($sformatf("auto step%0d valids", s), 32'(nval), 32'd1);
            check($sformatf("auto step%0d sec", s), {24'd0, last_sec},
                  (s == 0) ? 32'h10 : (s == 1) ? 32'h09 : 32'h08);
        end
        nval = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid_a) nval++;
        end
        check("auto held no valid", 32'(nval), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
